// File: rtl/wb_slave_mux_if.sv
// Wishbone classic bus bundle between one master, the slave mux and N slaves.
// Modport slave is the mux side; modport master is the side that drives requests and slave replies.
interface wb_slave_mux_if #(
    parameter int unsigned SLAVES = 16,
    parameter int unsigned AW     = 28,
    parameter int unsigned DW     = 32
);
    logic                   cyc_i;
    logic                   stb_i;
    logic                   we_i;
    logic [AW-1:0]          adr_i;
    logic [DW-1:0]          dat_i;
    logic [DW/8-1:0]        sel_i;
    logic                   ack_o;
    logic                   err_o;
    logic [DW-1:0]          dat_o;
    logic [SLAVES-1:0]      slv_cyc_o;
    logic [SLAVES-1:0]      slv_stb_o;
    logic                   slv_we_o;
    logic [AW-1:0]          slv_adr_o;
    logic [DW-1:0]          slv_dat_o;
    logic [DW/8-1:0]        slv_sel_o;
    logic [SLAVES-1:0]      slv_ack_i;
    logic [SLAVES-1:0]      slv_err_i;
    logic [SLAVES*DW-1:0]   slv_dat_i;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, err_o, dat_o,
        output slv_cyc_o, slv_stb_o, slv_we_o, slv_adr_o, slv_dat_o, slv_sel_o,
        input  slv_ack_i, slv_err_i, slv_dat_i
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, err_o, dat_o,
        input  slv_cyc_o, slv_stb_o, slv_we_o, slv_adr_o, slv_dat_o, slv_sel_o,
        output slv_ack_i, slv_err_i, slv_dat_i
    );
endinterface

// File: rtl/wb_slave_mux.sv
// Registered Wishbone classic 1:N decoder/mux with write path, population mask, unmapped bus
// error and per-transfer watchdog. Define WB_MUX_STATS_EN to add err_cnt_o / err_adr_o.
module wb_slave_mux #(
    parameter int unsigned          SLAVES     = 16,
    parameter int unsigned          SW         = $clog2(SLAVES),
    parameter int unsigned          AW         = 28,
    parameter int unsigned          DW         = 32,
    parameter logic [SLAVES-1:0]    SLAVE_MASK = {SLAVES{1'b1}},
    parameter int unsigned          TIMEOUT    = 255,
    parameter int unsigned          TW         = $clog2(TIMEOUT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_slave_mux_if.slave       bus
`ifdef WB_MUX_STATS_EN
    ,
    output logic [15:0]         err_cnt_o,
    output logic [AW-1:0]       err_adr_o
`endif
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e             state;
    logic [SW-1:0]      idx;
    logic [TW-1:0]      cnt;

    logic [SW-1:0]      req_idx;
    logic [SLAVES-1:0]  req_onehot;
    logic               req_mapped;
    logic               sel_ack;
    logic               sel_err;
    logic [DW-1:0]      sel_dat;
    logic [TW-1:0]      cnt_next;
    logic               timeout_hit;

    // Decode of the incoming request; indices beyond SLAVES are treated as unmapped.
    always_comb begin
        req_idx    = bus.adr_i[AW-1 -: SW];
        req_onehot = SLAVES'(1) << req_idx;
        req_mapped = 1'b0;
        if (32'(req_idx) < SLAVES) begin
            req_mapped = SLAVE_MASK[req_idx];
        end
    end

    // Only the addressed slave's reply lines are observed during BUSY.
    always_comb begin
        sel_ack     = bus.slv_ack_i[idx];
        sel_err     = bus.slv_err_i[idx];
        sel_dat     = bus.slv_dat_i[idx*DW +: DW];
        cnt_next    = cnt + 1'b1;
        timeout_hit = (cnt_next == TW'(TIMEOUT));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= StIdle;
            idx           <= '0;
            cnt           <= '0;
            bus.ack_o     <= 1'b0;
            bus.err_o     <= 1'b0;
            bus.dat_o     <= '0;
            bus.slv_cyc_o <= '0;
            bus.slv_stb_o <= '0;
            bus.slv_we_o  <= 1'b0;
            bus.slv_adr_o <= '0;
            bus.slv_dat_o <= '0;
            bus.slv_sel_o <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    bus.ack_o <= 1'b0;
                    bus.err_o <= 1'b0;
                    if (bus.cyc_i && bus.stb_i) begin
                        idx           <= req_idx;
                        bus.slv_we_o  <= bus.we_i;
                        bus.slv_adr_o <= bus.adr_i;
                        bus.slv_dat_o <= bus.dat_i;
                        bus.slv_sel_o <= bus.sel_i;
                        if (req_mapped) begin
                            state         <= StBusy;
                            cnt           <= '0;
                            bus.slv_cyc_o <= req_onehot;
                            bus.slv_stb_o <= req_onehot;
                        end else begin
                            state     <= StResp;
                            bus.err_o <= 1'b1;
                        end
                    end
                end
                StBusy: begin
                    if (!bus.cyc_i) begin
                        // Master abort: drop the slave quietly, no response.
                        state         <= StIdle;
                        bus.slv_cyc_o <= '0;
                        bus.slv_stb_o <= '0;
                    end else if (sel_err || sel_ack || timeout_hit) begin
                        state         <= StResp;
                        bus.slv_cyc_o <= '0;
                        bus.slv_stb_o <= '0;
                        // Error beats ack; timeout only fires when the slave stayed silent.
                        if (sel_err || !sel_ack) begin
                            bus.err_o <= 1'b1;
                        end else begin
                            bus.ack_o <= 1'b1;
                            if (!bus.slv_we_o) begin
                                bus.dat_o <= sel_dat;
                            end
                        end
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    bus.ack_o <= 1'b0;
                    bus.err_o <= 1'b0;
                end
                default: begin
                    state         <= StIdle;
                    bus.ack_o     <= 1'b0;
                    bus.err_o     <= 1'b0;
                    bus.slv_cyc_o <= '0;
                    bus.slv_stb_o <= '0;
                end
            endcase
        end
    end

`ifdef WB_MUX_STATS_EN
    // The latched address is still stable while err_o is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
            err_adr_o <= '0;
        end else if (bus.err_o) begin
            if (err_cnt_o != 16'hFFFF) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
            err_adr_o <= bus.slv_adr_o;
        end
    end
`endif

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux: table of single transfers plus hand sequences for abort and
// asynchronous reset. DUT built with SLAVE_MASK=16'h00FF and TIMEOUT=8.
module tb_wb_slave_mux;

    logic clk;
    logic rst;

    wb_slave_mux_if #(.SLAVES(16), .AW(28), .DW(32)) bus ();

`ifdef WB_MUX_STATS_EN
    logic [15:0] err_cnt;
    logic [27:0] err_adr;
`endif

    wb_slave_mux #(
        .SLAVES     (16),
        .AW         (28),
        .DW         (32),
        .SLAVE_MASK (16'h00FF),
        .TIMEOUT    (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus)
`ifdef WB_MUX_STATS_EN
        ,
        .err_cnt_o  (err_cnt),
        .err_adr_o  (err_adr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // mode: 0 ack, 1 err, 2 ack+err together; k = strobe cycle of the reply, 0 = never replies.
    typedef struct {
        logic        we;
        logic [27:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        int          k;
        int          mode;
        logic [31:0] rdat;
        logic        noise;
        logic [15:0] exp_stb;
        int          exp_stb_cyc;
        int          exp_acks;
        int          exp_errs;
        int          exp_resp;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          sidx;
        int          s;
        int          acks;
        int          errs;
        int          both;
        int          cycmis;
        int          resp;
        logic [15:0] stb_or;
        logic [15:0] onehot;
        logic [27:0] seen_adr;
        logic        seen_we;
        logic [31:0] seen_dat;
        logic [3:0]  seen_sel;
        string       tag;
        sidx = int'(v.adr[27:24]);
        onehot = 16'(1) << sidx;
        s = 0; acks = 0; errs = 0; both = 0; cycmis = 0; resp = -1; stb_or = '0;
        seen_adr = '0; seen_we = 1'b0; seen_dat = '0; seen_sel = '0;
        for (int i = 0; i < 16; i++) bus.slv_dat_i[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
        bus.slv_dat_i[sidx*32 +: 32] = v.rdat;
        bus.slv_ack_i = v.noise ? ~onehot : 16'h0;
        bus.slv_err_i = v.noise ? ~onehot : 16'h0;
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = v.we;
        bus.adr_i = v.adr;
        bus.dat_i = v.wdat;
        bus.sel_i = v.sel;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (bus.ack_o && bus.err_o) both++;
            if (bus.slv_cyc_o !== bus.slv_stb_o) cycmis++;
            if (bus.slv_stb_o != 16'h0) begin
                s++;
                stb_or   = stb_or | bus.slv_stb_o;
                seen_adr = bus.slv_adr_o;
                seen_we  = bus.slv_we_o;
                seen_dat = bus.slv_dat_o;
                seen_sel = bus.slv_sel_o;
            end
            if (bus.ack_o) begin acks++; resp = n; end
            if (bus.err_o) begin errs++; resp = n; end
            if (bus.ack_o || bus.err_o) begin
                bus.cyc_i = 1'b0;
                bus.stb_i = 1'b0;
            end
            bus.slv_ack_i = v.noise ? ~onehot : 16'h0;
            bus.slv_err_i = v.noise ? ~onehot : 16'h0;
            if (bus.slv_stb_o[sidx] && s == v.k) begin
                if (v.mode != 1) bus.slv_ack_i[sidx] = 1'b1;
                if (v.mode != 0) bus.slv_err_i[sidx] = 1'b1;
            end
        end
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.slv_ack_i = '0;
        bus.slv_err_i = '0;
        tag = $sformatf("v%0d", id);
        chk({tag, "_stb"}, stb_or, v.exp_stb);
        chk({tag, "_stb_cycles"}, s, v.exp_stb_cyc);
        chk({tag, "_acks"}, acks, v.exp_acks);
        chk({tag, "_errs"}, errs, v.exp_errs);
        chk({tag, "_resp_cycle"}, resp, v.exp_resp);
        chk({tag, "_dat_o"}, bus.dat_o, v.exp_dat);
        chk({tag, "_ack_err_overlap"}, both, 0);
        chk({tag, "_cyc_eq_stb"}, cycmis, 0);
        if (v.exp_stb != 16'h0) begin
            chk({tag, "_slv_adr"}, seen_adr, v.adr);
            chk({tag, "_slv_we"}, seen_we, v.we);
            if (v.we) begin
                chk({tag, "_slv_dat"}, seen_dat, v.wdat);
                chk({tag, "_slv_sel"}, seen_sel, v.sel);
            end
        end
    endtask

    initial begin
        int noresp;
        //          we    adr          wdat          sel   k  mode rdat          noise exp_stb  cyc acks errs resp exp_dat
        vecs[0] = '{1'b0, 28'h3000010, 32'h0,        4'hF, 3, 0, 32'hDEADBEEF, 1'b0, 16'h0008, 3, 1, 0, 4, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 28'h0000000, 32'h12345678, 4'h3, 1, 0, 32'h99999999, 1'b0, 16'h0001, 1, 1, 0, 2, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 28'hA000000, 32'h0,        4'hF, 1, 0, 32'h77777777, 1'b0, 16'h0000, 0, 0, 1, 1, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 28'h5000000, 32'h0,        4'hF, 0, 0, 32'h55555555, 1'b1, 16'h0020, 8, 0, 1, 9, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 28'h1000004, 32'h0,        4'hF, 2, 2, 32'h11111111, 1'b0, 16'h0002, 2, 0, 1, 3, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 28'h7FFFFFC, 32'h0,        4'hF, 1, 0, 32'hA5A55A5A, 1'b0, 16'h0080, 1, 1, 0, 2, 32'hA5A55A5A};
        vecs[6] = '{1'b0, 28'h2000100, 32'h0,        4'hF, 2, 1, 32'hCCCCCCCC, 1'b0, 16'h0004, 2, 0, 1, 3, 32'hA5A55A5A};
        vecs[7] = '{1'b1, 28'hFFFFFFF, 32'hFFFF0000, 4'hC, 1, 0, 32'h0,        1'b0, 16'h0000, 0, 0, 1, 1, 32'hA5A55A5A};

        rst = 1'b0;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = '0;
        bus.slv_ack_i = '0; bus.slv_err_i = '0; bus.slv_dat_i = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", bus.ack_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_dat_o", bus.dat_o, 32'h0);
        chk("rst_slv_cyc", bus.slv_cyc_o, 16'h0);
        chk("rst_slv_stb", bus.slv_stb_o, 16'h0);
        chk("rst_slv_we", bus.slv_we_o, 1'b0);
        chk("rst_slv_adr", bus.slv_adr_o, 28'h0);
        chk("rst_slv_dat", bus.slv_dat_o, 32'h0);
        chk("rst_slv_sel", bus.slv_sel_o, 4'h0);
`ifdef WB_MUX_STATS_EN
        chk("rst_err_cnt", err_cnt, 16'h0);
        chk("rst_err_adr", err_adr, 28'h0);
`endif
        rst = 1'b0;

        // Master abort two cycles into BUSY on slave 4 (never replies).
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 28'h4000000;
        tick();
        chk("abort_stb_c1", bus.slv_stb_o, 16'h0010);
        tick();
        chk("abort_stb_c2", bus.slv_stb_o, 16'h0010);
        chk("abort_cyc_c2", bus.slv_cyc_o, 16'h0010);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        tick();
        chk("abort_stb_c3", bus.slv_stb_o, 16'h0);
        chk("abort_cyc_c3", bus.slv_cyc_o, 16'h0);
        noresp = (bus.ack_o || bus.err_o) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.ack_o || bus.err_o || bus.slv_stb_o != 16'h0) noresp++;
        end
        chk("abort_no_resp", noresp, 0);

        // Asynchronous reset in the middle of a BUSY transfer, checked between clock edges.
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 28'h3000010;
        tick();
        chk("rstmid_pre_stb", bus.slv_stb_o, 16'h0008);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_stb", bus.slv_stb_o, 16'h0);
        chk("rstmid_cyc", bus.slv_cyc_o, 16'h0);
        chk("rstmid_adr", bus.slv_adr_o, 28'h0);
        chk("rstmid_ack_err", {bus.ack_o, bus.err_o}, 2'b00);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        noresp = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.ack_o || bus.err_o || bus.slv_stb_o != 16'h0) noresp++;
        end
        chk("rstmid_quiet", noresp, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

`ifdef WB_MUX_STATS_EN
        chk("stats_err_cnt", err_cnt, 16'd5);
        chk("stats_err_adr", err_adr, 28'hFFFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
